usrt_tx: RTL and testbench
==========================

Name: usrt_tx

Overview:
- USRT transmitter: the sending end of the synchronous serial link that usrt_rec receives. Serialises calculator result bytes back to the host.
- Generates its own serial clock from clk16M.
- Holds a small byte FIFO so cmd_interp and the result formatter can queue several bytes without waiting on the line.
- Sits beside usrt_rec in calc_top; frame format is identical to the receive direction.

Parameters:
- DIV, 8: clk cycles per serial-clock half-period; must be ≥1. Bit period = 2*DIV clk cycles.
- DEPTH, 4: FIFO depth in bytes; power of two, ≥2.

Ports:
- clk  input  1  system clock (clk16M).
- rst  input  1  asynchronous, active-high reset.
- data  input  8  byte to enqueue.
- strt  input  1  one-cycle write strobe; enqueues data.
- tx  output  1  serial data line; idle 1.
- usrt_clk  output  1  serial clock; idle 1.
- rdy  output  1  one-cycle pulse when a frame's stop bit completes.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- full  output  1  FIFO holds DEPTH bytes.
- ovf  output  1  one-cycle pulse when strt arrives while full.

Behaviour:
- Reset (async): tx=1, usrt_clk=1, rdy=0, busy=0, full=0, ovf=0. FIFO is emptied, FSM goes to IDLE, divider and bit counter clear. Reset mid-frame aborts the frame immediately with no partial stop bit.
- Frame: start bit 0, then 8 data bits LSB first, then stop bit 1; 10 bit periods in total.
- Bit timing:
  - Each bit period starts with usrt_clk falling and tx updating on the same clk edge.
  - usrt_clk rises DIV cycles later; the receiver samples on this edge.
  - usrt_clk toggles only during START/DATA/STOP and is held at 1 otherwise.
- FIFO write:
  - strt with count<DEPTH stores data at the write pointer; count increments next cycle.
  - strt with count==DEPTH drops the byte and pulses ovf on the next cycle.
  - full is decided from the current count only. A same-cycle pop does not make room for a push; the push is dropped.
  - strt is ignored while rst=1.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: if FIFO non-empty, pop the head into the shift register and go to START on the next clk. From strt into an empty FIFO, tx falls 2 cycles later (cycle k strt, k+1 non-empty, k+2 START with tx=0).
  - START: 1 bit period with tx=0, then DATA.
  - DATA: 8 bit periods, shifting right; tx = shift[0]. A bit counter of 0..7 selects the exit to STOP.
  - STOP: 1 bit period with tx=1. At its last cycle, rdy pulses for 1 cycle, then GAP.
  - GAP: 1 bit period with tx=1 and usrt_clk=1 (minimum inter-frame idle), then IDLE. Back-to-back frames are therefore spaced 11 bit periods plus 1 cycle apart.
- Divider: counts 0..DIV-1. The wrap toggles usrt_clk within START/DATA/STOP. Every second wrap (the rising edge followed by a half period) ends the bit period. The divider is reset on entry to START.
- busy = (state≠IDLE) OR (count≠0).
- Counter widths: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, GAP=4, 3 bits).
  - FRAME_BITS=10.
  - The idle-level constant (1), shared with usrt_rec.
- One sub-module, usrt_tx_fifo (parameter DEPTH, width 8):
  - Ports: clk, rst, wr, din, rd, dout, count, full, empty.
  - Gives first-word fall-through read.
- The FSM, divider and shift register stay in usrt_tx.

Test Plan:
- DIV=8, strt with data=8'hA5 → tx falls 2 cycles later. On the 10 rising edges of usrt_clk, tx reads 0,1,0,1,0,0,1,0,1,1. The frame lasts 160 cycles, rdy pulses once at its end, and busy deasserts 17 cycles after rdy.
- DIV=8, 4 consecutive strt with 8'h01..8'h04 → full=1 after the 4th write. A 5th strt of 8'hFF in the next cycle produces an ovf pulse, and 8'hFF is never sent.
  - Caveat: this expectation holds only if no pop has yet occurred. The first pop happens one cycle after the first write, so the bench must pre-fill while a frame is already active.
  - Four frames follow (01, 02, 03, 04) with GAP=16 cycles between stop bit and next start bit.
- rst asserted mid-DATA of byte 8'h3C with 2 bytes queued → tx=1 and usrt_clk=1 in the same cycle (async). After release: busy=0, full=0, and no further frames are sent.
- DIV=1 corner, data=8'h80 → bit period of 2 cycles, usrt_clk toggling every cycle, frame of 20 cycles. Bits read 0,0,0,0,0,0,0,0,1,1.
- Loopback: tx and usrt_clk driven into usrt_rec (rx, usrt_clk) with DIV=8 and 64 random bytes, writes paced to avoid ovf → usrt_rec data equals the sent sequence, with one rdy on each side per byte.

Source files
------------

// File: rtl/usrt_tx_pkg.sv
// Shared definitions for the USRT transmit path: FSM encoding and frame constants.
package usrt_tx_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StGap   = 3'd4
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;
    // Line level for both tx and usrt_clk when no frame is on the wire; usrt_rec relies on it.
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/usrt_tx_fifo.sv
// Byte FIFO with first-word fall-through read; pushes into a full FIFO are dropped.
module usrt_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [7:0]               din,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Full is judged on the current count only, so a same-cycle pop never admits a push.
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/usrt_tx.sv
// USRT transmitter: queues bytes and sends start/8 data LSB first/stop frames with its own
// serial clock, followed by a one-bit idle gap.
module usrt_tx #(
    parameter int unsigned DIV   = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       strt,
    output logic       tx,
    output logic       usrt_clk,
    output logic       rdy,
    output logic       busy,
    output logic       full,
    output logic       ovf
);
    import usrt_tx_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = (DIV > 1) ? DW'(DIV - 2) : '0;

    tx_state_e     state;
    logic [DW-1:0] div;
    logic          phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic          fifo_rd;
    logic [7:0]    fifo_dout;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wrap;
    logic          bit_end;
    logic          rdy_pre;

    usrt_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (strt),
        .din   (data),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_rd = (state == StIdle) && !fifo_empty;
    assign wrap    = (div == DIV_LAST);
    assign bit_end = wrap && phase;
    // True one cycle before the final cycle of a bit period, so registered rdy lands on it.
    assign rdy_pre = (DIV == 1) ? !phase : (phase && div == DIV_PRE);
    assign busy    = (state != StIdle) || (fifo_count != '0);
    assign full    = fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            div      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= IDLE_LEVEL;
            usrt_clk <= IDLE_LEVEL;
            rdy      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= strt && fifo_full;
            rdy <= (state == StStop) && rdy_pre;

            if (state != StIdle) begin
                div <= wrap ? '0 : div + 1'b1;
                if (wrap) phase <= !phase;
            end
            // Mid-bit wrap raises the clock; the bit-end wrap drops it except after the stop bit.
            if (wrap && (state inside {StStart, StData, StStop})) begin
                usrt_clk <= !phase || (state == StStop);
            end

            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        state    <= StStart;
                        tx       <= 1'b0;
                        usrt_clk <= 1'b0;
                        div      <= '0;
                        phase    <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state   <= StData;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= StStop;
                            tx    <= IDLE_LEVEL;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (bit_end) state <= StGap;
                end
                StGap: begin
                    if (bit_end) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx.sv
// Bench for usrt_tx: table of single frames at DIV=8 and DIV=1, FIFO overflow, mid-frame reset
// and a random loopback into a behavioural bit-level receiver.
module tb_usrt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       strt;
    logic       sel;  // 0 selects the DIV=8 instance, 1 the DIV=1 instance

    logic tx8, uclk8, rdy8, busy8, full8, ovf8;
    logic tx1, uclk1, rdy1, busy1, full1, ovf1;
    logic strt8, strt1;
    logic tx_s, uclk_s, rdy_s, busy_s;

    always #5 clk = ~clk;

    assign strt8  = strt && !sel;
    assign strt1  = strt && sel;
    assign tx_s   = sel ? tx1 : tx8;
    assign uclk_s = sel ? uclk1 : uclk8;
    assign rdy_s  = sel ? rdy1 : rdy8;
    assign busy_s = sel ? busy1 : busy8;

    usrt_tx #(.DIV(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .data(data), .strt(strt8), .tx(tx8), .usrt_clk(uclk8),
        .rdy(rdy8), .busy(busy8), .full(full8), .ovf(ovf8)
    );

    usrt_tx #(.DIV(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .strt(strt1), .tx(tx1), .usrt_clk(uclk1),
        .rdy(rdy1), .busy(busy1), .full(full1), .ovf(ovf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference receiver on the DIV=8 line: samples tx on every rising serial clock edge.
    logic [7:0] rx_q[$];
    logic [9:0] rx_sh;
    int         rx_bits   = 0;
    int         frame_err = 0;

    always @(posedge uclk8 or posedge rst) begin
        if (rst) begin
            rx_bits = 0;
        end else begin
            rx_sh[rx_bits] = tx8;
            rx_bits++;
            if (rx_bits == 10) begin
                if (rx_sh[0] !== 1'b0 || rx_sh[9] !== 1'b1) frame_err++;
                rx_q.push_back(rx_sh[8:1]);
                rx_bits = 0;
            end
        end
    end

    // Pulse counters and frame-start times (a fall of usrt_clk after a long high run).
    int cyc       = 0;
    int run8      = 1000;
    int rdy8_cnt  = 0;
    int ovf8_cnt  = 0;
    int starts_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rdy8 === 1'b1) rdy8_cnt++;
        if (ovf8 === 1'b1) ovf8_cnt++;
        if (uclk8 === 1'b1) begin
            run8++;
        end else begin
            if (run8 > 16) starts_q.push_back(cyc);
            run8 = 0;
        end
    end

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic [9:0] bits;  // bit i = value seen at the i-th rising usrt_clk edge
    } vec_t;

    vec_t vecs[6];

    task automatic run_frame(input logic s, input logic [7:0] d, input logic [9:0] exp_bits);
        int         dv;
        int         lat;
        int         idx;
        int         rdy_idx;
        int         rdy_n;
        int         n_rise;
        logic       prev_uclk;
        logic [9:0] got;
        string      tag;
        dv  = s ? 1 : 8;
        tag = $sformatf("%s_%02h", s ? "div1" : "div8", d);
        @(negedge clk);
        sel  = s;
        data = d;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        check({tag, "_tx_hold"}, 32'(tx_s), 32'd1);
        lat = 1;
        while (tx_s !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_start_latency"}, lat, 2);
        check({tag, "_uclk_fall"}, 32'(uclk_s), 32'd0);
        idx       = 0;
        n_rise    = 0;
        got       = '0;
        rdy_idx   = -1;
        rdy_n     = 0;
        prev_uclk = uclk_s;
        while (busy_s === 1'b1 && idx < 1000) begin
            @(negedge clk);
            idx++;
            if (prev_uclk === 1'b0 && uclk_s === 1'b1) begin
                if (n_rise < 10) got[n_rise] = tx_s;
                n_rise++;
            end
            if (rdy_s === 1'b1) begin
                rdy_n++;
                rdy_idx = idx;
            end
            prev_uclk = uclk_s;
        end
        check({tag, "_rises"}, n_rise, 10);
        check({tag, "_bits"}, 32'(got), 32'(exp_bits));
        check({tag, "_rdy_count"}, rdy_n, 1);
        check({tag, "_rdy_at_frame_end"}, rdy_idx, 20 * dv - 1);
        check({tag, "_busy_off_after_rdy"}, idx - rdy_idx, 2 * dv + 1);
        check({tag, "_tx_idle"}, 32'(tx_s), 32'd1);
    endtask

    logic [7:0] sent[$];
    logic [7:0] exp_ovf[5];
    int         rx0;
    int         s0;
    int         r0;
    int         o0;
    int         w;
    int         bad;
    int         timeouts;
    logic [7:0] b;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 10'b1101001010};
        vecs[1] = '{1'b0, 8'h00, 10'b1000000000};
        vecs[2] = '{1'b0, 8'hFF, 10'b1111111110};
        vecs[3] = '{1'b1, 8'h80, 10'b1100000000};
        vecs[4] = '{1'b1, 8'h5A, 10'b1010110100};
        vecs[5] = '{1'b1, 8'h3C, 10'b1001111000};

        rst  = 1'b1;
        strt = 1'b0;
        data = 8'h00;
        sel  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx8), 32'd1);
        check("rst_usrt_clk", 32'(uclk8), 32'd1);
        check("rst_flags", {28'd0, rdy8, busy8, full8, ovf8}, 32'd0);
        check("rst_div1_lines", {30'd0, tx1, uclk1}, 32'd3);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i].sel, vecs[i].data, vecs[i].bits);

        // Overflow: fill the FIFO while a frame is already on the wire so no pop interferes.
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = rx_q.size();
        starts_q.delete();
        data = 8'hAA;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        w = 0;
        while (tx8 !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("ovf_first_start", w, 1);
        for (int i = 1; i <= 4; i++) begin
            data = 8'(i);
            strt = 1'b1;
            @(negedge clk);
        end
        check("ovf_full_after_4", 32'(full8), 32'd1);
        check("ovf_no_early_pulse", 32'(ovf8), 32'd0);
        data = 8'hFF;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        check("ovf_pulse", 32'(ovf8), 32'd1);
        @(negedge clk);
        check("ovf_one_cycle", 32'(ovf8), 32'd0);
        w = 0;
        while (busy8 === 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("ovf_drained", 32'(busy8), 32'd0);
        exp_ovf = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
        check("ovf_frame_count", rx_q.size() - rx0, 5);
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() > rx0 + i) check($sformatf("ovf_byte%0d", i), 32'(rx_q[rx0 + i]),
                                             32'(exp_ovf[i]));
        end
        check("ovf_start_count", starts_q.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (starts_q.size() > i) check($sformatf("ovf_spacing%0d", i),
                                           starts_q[i] - starts_q[i - 1], 177);
        end

        // Reset in the middle of the data bits of 3C with 11 and 22 still queued.
        @(negedge clk);
        data = 8'h3C;
        strt = 1'b1;
        @(negedge clk);
        data = 8'h11;
        @(negedge clk);
        data = 8'h22;
        @(negedge clk);
        strt = 1'b0;
        repeat (40) @(negedge clk);
        w = 0;
        while (uclk8 !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mid_busy", 32'(busy8), 32'd1);
        check("mid_uclk_low", 32'(uclk8), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_tx", 32'(tx8), 32'd1);
        check("arst_usrt_clk", 32'(uclk8), 32'd1);
        check("arst_busy_full", {30'd0, busy8, full8}, 32'd0);
        rx0 = rx_q.size();
        s0  = starts_q.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy_full", {30'd0, busy8, full8}, 32'd0);
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx8 !== 1'b1 || uclk8 !== 1'b1 || busy8 !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_no_frames", rx_q.size() - rx0, 0);
        check("post_rst_no_starts", starts_q.size() - s0, 0);

        // Loopback of random bytes, writes paced on full.
        sent.delete();
        rx0      = rx_q.size();
        r0       = rdy8_cnt;
        o0       = ovf8_cnt;
        timeouts = 0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            w = 0;
            while (full8 === 1'b1 && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 1000) timeouts++;
            data = b;
            strt = 1'b1;
            sent.push_back(b);
            @(negedge clk);
            strt = 1'b0;
        end
        w = 0;
        while (busy8 === 1'b1 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("lb_drained", 32'(busy8), 32'd0);
        check("lb_write_timeouts", timeouts, 0);
        check("lb_byte_count", rx_q.size() - rx0, 64);
        for (int i = 0; i < 64; i++) begin
            if (rx_q.size() > rx0 + i) check($sformatf("lb_byte%0d", i), 32'(rx_q[rx0 + i]),
                                             32'(sent[i]));
        end
        check("lb_rdy_count", rdy8_cnt - r0, 64);
        check("lb_no_ovf", ovf8_cnt - o0, 0);
        check("framing_errors", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
